// File: rtl/analog_io_master.sv
// analog_io_master
// Sequences one port access per host request: optional bus turnaround,
// settle interval, then either a write or an averaged read, closed by a
// one-cycle ack.
//
// Handshake: the host raises req (with wr/wdata) while busy is 0; the
// request is taken on that clock edge. Requests seen while busy is 1 are
// dropped. Each accepted request produces exactly one ack pulse, unless
// reset intervenes.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req, wr, wdata  host request, access type (1 = write), write data
//   ack             one-cycle end-of-access pulse
//   rdata           averaged read result, held until the next read's ack
//   busy            high whenever the sequencer is not idle
//   en, direction   port enable and direction (1 = drive out)
//   data_in         data presented to the port
//   data_out        value read back from the port
//   state_dbg       current FSM state (IDLE=0 TURN=1 SETTLE=2 SAMPLE=3 DONE=4)
module analog_io_master #(
    parameter int BITS       = 16,
    parameter int SETTLE_CYC = 4,
    parameter int TURN_CYC   = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            wr,
    input  logic [BITS-1:0] wdata,
    output logic            ack,
    output logic [BITS-1:0] rdata,
    output logic            busy,
    output logic            en,
    output logic            direction,
    output logic [BITS-1:0] data_in,
    input  logic [BITS-1:0] data_out,
    output logic [2:0]      state_dbg
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int ACC_W = BITS + AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TURN   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state, next_state;
    logic [15:0]        cnt;
    logic               wr_q;
    logic               dir_q;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic               en_d, ack_d, busy_d;
    logic               accept;

    assign accept    = (state == S_IDLE) && req;
    assign acc_sum   = acc + ACC_W'(data_out);
    assign state_dbg = state;
    assign direction = dir_q;

    // State register plus the registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            dir_q   <= 1'b0;
            acc     <= '0;
            rdata   <= '0;
            data_in <= '0;
            en      <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= next_state;
            en    <= en_d;
            ack   <= ack_d;
            busy  <= busy_d;

            // Per-state cycle counter restarts on every state change.
            if (next_state != state) cnt <= '0;
            else                     cnt <= cnt + 16'd1;

            if (accept) begin
                wr_q <= wr;
                // Direction flips only when entering TURN.
                if (wr != dir_q) dir_q <= wr;
                if (wr)          data_in <= wdata;
            end

            if (state == S_SETTLE && next_state == S_SAMPLE) acc <= '0;
            else if (state == S_SAMPLE)                      acc <= acc_sum;

            // Include the final sample so rdata lands with ack.
            if (state == S_SAMPLE && next_state == S_DONE)
                rdata <= BITS'(acc_sum >> AVG_LOG2);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req) next_state = (wr != dir_q) ? S_TURN : S_SETTLE;
            end
            S_TURN: begin
                if (cnt == 16'(TURN_CYC - 1)) next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == 16'(SETTLE_CYC - 1)) next_state = wr_q ? S_DONE : S_SAMPLE;
            end
            S_SAMPLE: begin
                if (cnt == 16'(N - 1)) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is registered.
    always_comb begin
        en_d   = (next_state == S_SETTLE) || (next_state == S_SAMPLE);
        ack_d  = (next_state == S_DONE);
        busy_d = (next_state != S_IDLE);
    end

endmodule

// File: tb/tb_analog_io_master.sv
module tb_analog_io_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        busy;
    logic        en;
    logic        direction;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [2:0]  state_dbg;

    int tests = 0;
    int fails = 0;

    // Per-cycle stimulus and captured trace, indexed by cycle after the request.
    logic [15:0] dout_tab [0:31];
    logic        en_tr    [0:31];
    logic        dir_tr   [0:31];
    logic        ack_tr   [0:31];
    logic        busy_tr  [0:31];
    logic [15:0] din_tr   [0:31];
    logic [15:0] rd_tr    [0:31];
    int          ncap;

    analog_io_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr        (wr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .en        (en),
        .direction (direction),
        .data_in   (data_in),
        .data_out  (data_out),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_dout(input logic [15:0] v);
        for (int i = 0; i < 32; i++) dout_tab[i] = v;
    endtask

    // Request in cycle 0, capture outputs for cycles 1..ncyc at the falling edge.
    // A nonzero pulse_at re-asserts req (with other data) in that cycle.
    task automatic access(input logic w, input logic [15:0] d, input int ncyc, input int pulse_at);
        @(posedge clk);
        #1;
        req = 1'b1; wr = w; wdata = d; data_out = dout_tab[0];
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c == pulse_at) begin
                req = 1'b1; wdata = 16'h9999;
            end else begin
                req = 1'b0;
            end
            data_out = dout_tab[c];
            @(negedge clk);
            en_tr[c] = en; dir_tr[c] = direction; ack_tr[c] = ack;
            busy_tr[c] = busy; din_tr[c] = data_in; rd_tr[c] = rdata;
        end
        ncap = ncyc;
    endtask

    function automatic int first_ack();
        for (int c = 1; c <= ncap; c++) if (ack_tr[c]) return c;
        return -1;
    endfunction

    function automatic int ack_count();
        int n = 0;
        for (int c = 1; c <= ncap; c++) if (ack_tr[c]) n++;
        return n;
    endfunction

    function automatic int en_count(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (en_tr[c]) n++;
        return n;
    endfunction

    function automatic int dir_count(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (dir_tr[c]) n++;
        return n;
    endfunction

    initial begin
        int idle_acks;

        // Reset
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; wdata = '0; data_out = '0;
        fill_dout(16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en", en, 0);
        check("rst_dir", direction, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_data_in", data_in, 0);
        check("rst_rdata", rdata, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;

        // Read of a constant, no turnaround
        fill_dout(16'h1234);
        access(1'b0, 16'h0000, 12, 0);
        check("rd_ack_cyc", first_ack(), 9);
        check("rd_ack_cnt", ack_count(), 1);
        check("rd_en_cnt", en_count(1, 8), 8);
        check("rd_en_done", en_tr[9], 0);
        check("rd_rdata", rd_tr[9], 16'h1234);
        check("rd_dir", dir_count(1, 12), 0);
        check("rd_busy_1", busy_tr[1], 1);
        check("rd_busy_10", busy_tr[10], 0);

        // Write with turnaround
        access(1'b1, 16'hBEEF, 10, 0);
        check("wr_dir_1", dir_tr[1], 1);
        check("wr_en_turn", en_count(1, 2), 0);
        check("wr_en_settle", en_count(3, 6), 4);
        check("wr_din_1", din_tr[1], 16'hBEEF);
        check("wr_ack_cyc", first_ack(), 7);
        check("wr_en_done", en_tr[7], 0);
        check("wr_busy_8", busy_tr[8], 0);

        // Back-to-back writes, second request in cycle L+1
        access(1'b1, 16'h1111, 5, 0);
        check("b2b1_ack_cyc", first_ack(), 5);
        check("b2b1_en_done", en_tr[5], 0);
        check("b2b1_en_1", en_tr[1], 1);
        access(1'b1, 16'h2222, 8, 0);
        check("b2b2_ack_cyc", first_ack(), 5);
        check("b2b2_en_1", en_tr[1], 1);
        check("b2b2_din", din_tr[1], 16'h2222);
        check("b2b2_dir", dir_count(1, 8), 8);

        // Request during SETTLE is dropped
        access(1'b1, 16'h3333, 14, 3);
        check("drop_ack_cnt", ack_count(), 1);
        check("drop_ack_cyc", first_ack(), 5);
        check("drop_din", din_tr[14], 16'h3333);

        // Averaged read of a ramp, with turnaround back to read
        fill_dout(16'h0000);
        dout_tab[7] = 16'h0001; dout_tab[8] = 16'h0002;
        dout_tab[9] = 16'h0003; dout_tab[10] = 16'h0004;
        access(1'b0, 16'h0000, 13, 0);
        check("avg_dir_1", dir_tr[1], 0);
        check("avg_ack_cyc", first_ack(), 11);
        check("avg_rdata", rd_tr[11], 16'h0002);
        check("avg_rdata_held", rd_tr[13], 16'h0002);
        check("avg_din_kept", din_tr[13], 16'h3333);

        // Full-scale read must not overflow
        fill_dout(16'hFFFF);
        access(1'b0, 16'h0000, 10, 0);
        check("max_ack_cyc", first_ack(), 9);
        check("max_rdata", rd_tr[9], 16'hFFFF);

        // Reset during a read's SAMPLE phase
        access(1'b1, 16'hA5A5, 9, 0);
        fill_dout(16'h0100);
        access(1'b0, 16'h0000, 8, 0);
        check("mid_en_before", en_tr[8], 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_en", en, 0);
        check("mid_busy", busy, 0);
        check("mid_ack", ack, 0);
        check("mid_rdata", rdata, 0);
        check("mid_dir", direction, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_acks = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ack) idle_acks++;
        end
        check("mid_no_ack", idle_acks, 0);
        check("mid_idle_state", state_dbg, 0);
        fill_dout(16'h0042);
        access(1'b0, 16'h0000, 10, 0);
        check("post_en_1", en_tr[1], 1);
        check("post_ack_cyc", first_ack(), 9);
        check("post_rdata", rd_tr[9], 16'h0042);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
